pipelined_mux_n: RTL and testbench
==================================

Name: pipelined_mux_n

Overview:
Parametrised N-to-1 word multiplexer with a registered, back-pressured output. Successor to the combinational fixed 6-input selector in the ALU datapath: width and input count are generic. Out-of-range selects are flagged and counted. Output uses a 2-entry skid buffer, so in_ready is a register and not a combinational path from out_ready. Sits between the ALU operand/result sources and the result bus.

Parameters:
WIDTH, 32, data word width in bits
N, 6, number of inputs (2..16)
SEL_W, 3, select width; 2**SEL_W >= N is required (elaboration error otherwise)
DEFAULT_VAL, 0, WIDTH-bit word output when sel >= N
CNT_W, 16, width of the error counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  N*WIDTH  flattened inputs; input k = in_data[k*WIDTH +: WIDTH]
sel  in  SEL_W  input select, sampled with in_valid
in_valid  in  1  upstream word/select valid
in_ready  out  1  block can accept; registered
out_data  out  WIDTH  selected word
out_err  out  1  sel was >= N for this output word (out_data = DEFAULT_VAL)
out_valid  out  1  output valid
out_ready  in  1  downstream accept
err_cnt  out  CNT_W  saturating count of accepted out-of-range selects

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_err=0, in_ready=1, err_cnt=0, skid empty, rr_ptr=0.
- Accept when in_valid && in_ready. Transfer out when out_valid && out_ready.
- Selection is done at accept: word = (sel < N) ? input[sel] : DEFAULT_VAL; err = (sel >= N). Word and err travel together.
- Main register (out_*): loaded on accept if empty or being drained in the same cycle. Otherwise the accept goes to the skid register.
- Skid: when main drains and skid is full, skid moves to main the next cycle. in_ready <= !skid_full_next.
- Latency: accept in cycle t -> out_valid in cycle t+1 when the pipe is empty. Throughput 1 word/cycle with out_ready=1.
- While out_valid=1 && out_ready=0, out_data and out_err hold stable.
- in_data and sel changing without an accept have no effect.
- Simultaneous accept and drain with skid empty: new word goes to main, no bubble.
- Full: main and skid both valid -> in_ready=0. No accept occurs until a drain.
- err_cnt increments on each accepted word with err=1. It saturates at 2**CNT_W-1 and does not wrap.
- Ordering is strictly FIFO. No word is lost or duplicated.
- Reset mid-operation: all buffered words are discarded immediately and outputs return to reset values.

Optional Feature:
MUX_AUTO_SEL_EN
- Defined: adds input port auto_mode (1 bit). When auto_mode=1, sel is ignored and the internal rr_ptr is used. rr_ptr advances on every accept: 0,1,...,N-1,0. In this mode err is always 0.
- auto_mode=0: rr_ptr holds its value and sel is used.
- Not defined: no auto_mode port, no rr_ptr. Behaviour is sel-only as above.

Test Plan:
1. Reset then idle: rst_n=0 with random inputs -> out_valid=0, in_ready=1, err_cnt=0. Release, hold in_valid=0 for 5 cycles -> no output.
2. Select sweep, out_ready=1: in_data inputs 0..5 = 32'h1000_000k, sel=0..7, one per cycle -> 8 outputs in order, one cycle later each. out_data = 32'h1000_0000..0005, then 32'h0 twice with out_err=1; err_cnt=2.
3. Back-pressure: out_ready=0, stream sel=1,2,3 with distinct data -> two accepts, then in_ready=0. Words 1 and 2 held stable. out_ready=1 -> words 1,2,3 emerge in order with no loss.
4. Simultaneous accept and drain at full rate for 20 random words (sel 0..7) -> output sequence equals the model, no bubbles after the first.
5. Saturation, CNT_W=2: 5 accepts with sel=7 -> err_cnt reads 1,2,3,3,3.
6. With MUX_AUTO_SEL_EN, auto_mode=1, sel=7 constant, 8 accepts -> data from inputs 0,1,2,3,4,5,0,1 with out_err=0. Assert rst_n=0 mid-stream -> out_valid=0 at once and rr_ptr restarts at 0.

Source files
------------

// File: rtl/pipelined_mux_n.sv
// pipelined_mux_n: N-to-1 word mux with registered, skid-buffered, back-pressured output.
// Define MUX_AUTO_SEL_EN to add the auto_mode port and round-robin select.
module pipelined_mux_n #(
    parameter int                WIDTH       = 32,
    parameter int                N           = 6,
    parameter int                SEL_W       = 3,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0,
    parameter int                CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
`ifdef MUX_AUTO_SEL_EN
    input  logic                 auto_mode,
`endif
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     err_cnt
);
    localparam logic [SEL_W:0] N_V = (SEL_W+1)'(N);

    if (N < 2 || N > 16 || (2**SEL_W) < N) begin : g_bad_cfg
        $error("pipelined_mux_n: need 2 <= N <= 16 and 2**SEL_W >= N");
    end

    // Select slots beyond N read DEFAULT_VAL, so the mux never indexes past in_data.
    logic [WIDTH-1:0] words [2**SEL_W];
    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_words
        if (k < N) begin : g_in
            assign words[k] = in_data[k*WIDTH +: WIDTH];
        end else begin : g_def
            assign words[k] = DEFAULT_VAL;
        end
    end

    logic [SEL_W-1:0] idx;
    logic             new_err;
`ifdef MUX_AUTO_SEL_EN
    localparam logic [SEL_W-1:0] N_M1 = SEL_W'(N - 1);
    logic [SEL_W-1:0] rr_ptr;
    assign idx     = auto_mode ? rr_ptr : sel;
    assign new_err = !auto_mode && ({1'b0, sel} >= N_V);
`else
    assign idx     = sel;
    assign new_err = {1'b0, sel} >= N_V;
`endif

    logic [WIDTH-1:0] word;
    logic             acc, drain, skid_valid, skid_next, skid_err;
    logic [WIDTH-1:0] skid_data;

    assign word      = words[idx];
    assign acc       = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    // in_ready is only ever low while the skid holds a word, so acc and a full skid never coincide.
    assign skid_next = skid_valid ? !drain : (acc && out_valid && !drain);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            in_ready   <= 1'b1;
            err_cnt    <= '0;
        end else begin
            skid_valid <= skid_next;
            in_ready   <= !skid_next;
            if (skid_valid) begin
                if (drain) begin
                    out_data <= skid_data;
                    out_err  <= skid_err;
                end
            end else if (acc) begin
                if (!out_valid || drain) begin
                    out_valid <= 1'b1;
                    out_data  <= word;
                    out_err   <= new_err;
                end else begin
                    skid_data <= word;
                    skid_err  <= new_err;
                end
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (acc && new_err && err_cnt != {CNT_W{1'b1}})
                err_cnt <= err_cnt + 1'b1;
        end
    end

`ifdef MUX_AUTO_SEL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (acc && auto_mode)
            rr_ptr <= (rr_ptr == N_M1) ? '0 : rr_ptr + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pipelined_mux_n.sv
// tb_pipelined_mux_n: directed + random stimulus against a 2-deep FIFO model of the mux.
// Also exercises MUX_AUTO_SEL_EN when that macro is defined.
module tb_pipelined_mux_n;
    localparam int W  = 32;
    localparam int N  = 6;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N*W-1:0]  in_data = '0;
    logic [SW-1:0]   sel = '0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            auto_mode = 1'b0;
    logic            in_ready, out_err, out_valid;
    logic [W-1:0]    out_data;
    logic [15:0]     err_cnt;
    logic            in_ready_s, out_err_s, out_valid_s;
    logic [W-1:0]    out_data_s;
    logic [1:0]      err_cnt_s;

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    int rr = 0;
    logic [W:0] q[$];

    always #5 clk = ~clk;

    pipelined_mux_n #(.WIDTH(W), .N(N), .SEL_W(SW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready),
`ifdef MUX_AUTO_SEL_EN
        .auto_mode(auto_mode),
`endif
        .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready), .err_cnt(err_cnt)
    );

    pipelined_mux_n #(.WIDTH(W), .N(N), .SEL_W(SW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready_s),
`ifdef MUX_AUTO_SEL_EN
        .auto_mode(auto_mode),
`endif
        .out_data(out_data_s), .out_err(out_err_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .err_cnt(err_cnt_s)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rand_data;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    endtask

    // One cycle: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic step;
        logic acc, drn;
        logic [W:0] w;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0][W-1:0]);
            chk("out_err", out_err, q[0][W]);
        end
        chk("err_cnt", err_cnt, cnt);
        chk("err_cnt_sat", err_cnt_s, cnt > 3 ? 3 : cnt);
        acc = in_valid && q.size() < 2;
        drn = q.size() > 0 && out_ready;
        if (auto_mode) w = {1'b0, in_data[rr*W +: W]};
        else if (sel < N) w = {1'b0, in_data[sel*W +: W]};
        else w = {1'b1, {W{1'b0}}};
        @(posedge clk);
        if (drn) void'(q.pop_front());
        if (acc) begin
            q.push_back(w);
            if (w[W]) cnt++;
            if (auto_mode) rr = (rr + 1) % N;
        end
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_cnt_sat", err_cnt_s, 0);
        q.delete();
        cnt = 0;
        rr = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with random inputs, then idle
        rand_data();
        sel = SW'($urandom);
        in_valid = 1'b1;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rand_data();
            sel = SW'($urandom);
            step();
        end
        // select sweep at full rate
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h1000_0000 + i;
        in_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = SW'(s);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("sweep_err_cnt", err_cnt, 2);
        // back-pressure: two accepts then stall, data churn must not matter
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            sel = SW'(k);
            rand_data();
            step();
        end
        for (int i = 0; i < 2; i++) begin
            rand_data();
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        // reset while the buffer is full
        out_ready = 1'b0;
        in_valid = 1'b1;
        sel = 3'd7;
        step();
        step();
        do_reset();
        // saturation on the 2-bit counter: 1,2,3,3,3
        out_ready = 1'b1;
        in_valid = 1'b1;
        sel = 3'd7;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0;
        step();
        chk("sat_hold", err_cnt_s, 3);
        // full-rate random stream
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            sel = SW'($urandom_range(0, 7));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        // random valid/ready mix
        for (int i = 0; i < 300; i++) begin
            rand_data();
            sel = SW'($urandom_range(0, 7));
            in_valid = 1'($urandom);
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
`ifdef MUX_AUTO_SEL_EN
        do_reset();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h2000_0000 + i;
        auto_mode = 1'b1;
        sel = 3'd7;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) step();
        in_valid = 1'b0;
        step();
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        auto_mode = 1'b0;
        step();
        step();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
